debounced_counter_bank: RTL and testbench

Multi-channel successor to the single-channel sync/debounce/counter/multiply datapath. Each channel synchronises and debounces an asynchronous count-enable pin, then drives its own up/down counter with a wrap or saturate mode, a sticky overflow flag and a synchronous clear. A shared, registered output stage returns the selected channel's count, or a scaled product of it, to the top-level pins.

---
 rtl/debounced_counter_pkg.sv | 24 ++
 rtl/debounced_counter_bank_input_conditioner.sv | 56 +++++
 rtl/debounced_counter_bank.sv | 114 +++++++++++
 tb/tb_debounced_counter_bank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounced_counter_pkg.sv
// Shared constants for the debounced counter bank: mode/direction encodings,
// default parameter values and the select-width helper.
package debounced_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_W        = 4;

  // Operand widths of the scaling multiplier.
  localparam int MUL_OP_W = 3;

  // A single channel still needs a 1-bit select port.
  function automatic int sel_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/debounced_counter_bank_input_conditioner.sv
// Per-channel conditioning of an asynchronous enable pin: a flop synchroniser
// followed by a persistence-count debouncer.
module input_conditioner
  import debounced_counter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_W        = DEF_DB_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_in,
  output logic en_db
);

  localparam logic [DB_W-1:0] DB_MAX = {DB_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   en_s;
  logic                   stable_q, stable_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], en_in};
  end

  assign en_s = sync_q[SYNC_STAGES-1];

  // Any cycle where the synchronised input agrees with the accepted level
  // restarts the persistence count, so short glitches leave no residue.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (en_s != stable_q) begin
      if (db_cnt_q == DB_MAX) begin
        stable_d = en_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign en_db = stable_q;

endmodule

// File: rtl/debounced_counter_bank.sv
// Bank of debounced up/down counters with wrap/saturate, sticky overflow and
// a registered output stage returning a selected count or a scaled product.
module debounced_counter_bank
  import debounced_counter_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_W        = DEF_DB_W,
  parameter int SEL_W       = sel_width(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     en_in,
  input  logic [N_CH-1:0]     dir,
  input  logic                sat_mode,
  input  logic [N_CH-1:0]     clr,
  input  logic [SEL_W-1:0]    sel,
  input  logic                mul_en,
  input  logic [MUL_OP_W-1:0] m_a,
  input  logic [MUL_OP_W-1:0] m_b,
  output logic [CNT_W-1:0]    data_out,
  output logic [N_CH-1:0]     ovf,
  output logic [N_CH-1:0]     en_db
);

  // Wide enough for m_a * m_b * 2^CNT_W without loss before truncation.
  localparam int PROD_W = CNT_W + 1 + 2 * MUL_OP_W;

  logic [CNT_W-1:0] cnt_arr [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    input_conditioner #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_W        (DB_W)
    ) u_cond (
      .clk   (clk),
      .rst_n (rst_n),
      .en_in (en_in[gi]),
      .en_db (en_db[gi])
    );

    // Clear beats everything; the boundary case flags overflow whether the
    // counter wraps or pins.
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr[gi]) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (en_db[gi]) begin
        if (dir[gi] == DIR_UP) begin
          if (&cnt_q) begin
            ovf_d = 1'b1;
            cnt_d = (sat_mode == MODE_SAT) ? cnt_q : '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == '0) begin
            ovf_d = 1'b1;
            cnt_d = (sat_mode == MODE_SAT) ? '0 : {CNT_W{1'b1}};
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign cnt_arr[gi] = cnt_q;
    assign ovf[gi]     = ovf_q;
  end

  logic [CNT_W-1:0]  cnt_sel;
  logic [PROD_W-1:0] prod_full;
  logic [CNT_W-1:0]  data_out_q, data_out_d;

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    cnt_sel = cnt_arr[0];
    if (int'(sel) < N_CH) begin
      cnt_sel = cnt_arr[sel];
    end
  end

  always_comb begin
    prod_full  = PROD_W'(m_a) * PROD_W'(m_b) * (PROD_W'(cnt_sel) + PROD_W'(1));
    data_out_d = mul_en ? prod_full[CNT_W-1:0] : cnt_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_debounced_counter_bank.sv
// Directed scoreboard bench: stimulus queues expected outputs, a negedge
// monitor pops and compares them against the DUT.
module tb_debounced_counter_bank;
  import debounced_counter_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int SEL_W = 2;

  localparam int K_DATA = 0;
  localparam int K_OVF  = 1;
  localparam int K_ENDB = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_CH-1:0]  en_in, dir, clr;
  logic             sat_mode, mul_en;
  logic [SEL_W-1:0] sel;
  logic [2:0]       m_a, m_b;
  logic [CNT_W-1:0] data_out;
  logic [N_CH-1:0]  ovf, en_db;

  always #5 clk = ~clk;

  debounced_counter_bank #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .DB_W        (4),
    .SEL_W       (SEL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_in    (en_in),
    .dir      (dir),
    .sat_mode (sat_mode),
    .clr      (clr),
    .sel      (sel),
    .mul_en   (mul_en),
    .m_a      (m_a),
    .m_b      (m_b),
    .data_out (data_out),
    .ovf      (ovf),
    .en_db    (en_db)
  );

  int checks   = 0;
  int failures = 0;

  string            q_name [$];
  int               q_kind [$];
  logic [CNT_W-1:0] q_exp  [$];

  task automatic expect_out(input string name, input int kind, input logic [CNT_W-1:0] exp);
    q_name.push_back(name);
    q_kind.push_back(kind);
    q_exp.push_back(exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q_exp.size() > 0) begin
      string            nm;
      int               k;
      logic [CNT_W-1:0] e, act;
      nm = q_name.pop_front();
      k  = q_kind.pop_front();
      e  = q_exp.pop_front();
      case (k)
        K_DATA:  act = data_out;
        K_OVF:   act = {{(CNT_W-N_CH){1'b0}}, ovf};
        default: act = {{(CNT_W-N_CH){1'b0}}, en_db};
      endcase
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, e, $time);
      end else begin
        $display("ok   %s: %0d (t=%0t)", nm, act, $time);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en_in = '0; dir = '1; clr = '0; sat_mode = MODE_WRAP;
    sel = '0; mul_en = 1'b0; m_a = '0; m_b = '0;

    // Reset holds everything at zero whatever the inputs do.
    for (int i = 0; i < 4; i++) begin
      en_in = 4'($urandom); dir = 4'($urandom); clr = 4'($urandom);
      sat_mode = 1'($urandom); sel = 2'($urandom); mul_en = 1'($urandom);
      m_a = 3'($urandom); m_b = 3'($urandom);
      tick(1);
      expect_out("rst_data", K_DATA, 8'd0);
      expect_out("rst_ovf",  K_OVF,  8'd0);
      expect_out("rst_endb", K_ENDB, 8'd0);
    end
    en_in = '0; dir = '1; clr = '0; sat_mode = MODE_WRAP;
    sel = '0; mul_en = 1'b0; m_a = '0; m_b = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      expect_out("post_rst_data", K_DATA, 8'd0);
      expect_out("post_rst_endb", K_ENDB, 8'd0);
    end

    // 10-cycle glitch is rejected.
    en_in[0] = 1'b1;
    tick(10);
    en_in[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      expect_out("glitch_endb", K_ENDB, 8'd0);
    end

    // Held level: en_db rises on edge 18, counting starts on edge 19.
    en_in[0] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      expect_out("latency_endb", K_ENDB, (k == 18) ? 8'h01 : 8'h00);
    end
    tick(101);
    expect_out("count_100", K_DATA, 8'd100);
    expect_out("count_ovf", K_OVF,  8'd0);

    // Wrap up from 255.
    clr[0] = 1'b1;
    tick(2);
    clr[0] = 1'b0;
    tick(255);
    expect_out("pre_wrap_data", K_DATA, 8'd254);
    expect_out("pre_wrap_ovf",  K_OVF,  8'd0);
    tick(1);
    expect_out("wrap_ovf",  K_OVF,  8'h01);
    expect_out("wrap_255",  K_DATA, 8'd255);
    tick(1);
    expect_out("wrap_cnt0",  K_DATA, 8'd0);
    expect_out("ovf_sticky", K_OVF,  8'h01);

    // Saturate up at 255.
    clr[0] = 1'b1; sat_mode = MODE_SAT;
    tick(2);
    clr[0] = 1'b0;
    tick(255);
    expect_out("pre_sat_ovf", K_OVF, 8'h00);
    tick(1);
    expect_out("sat_up_ovf",  K_OVF,  8'h01);
    expect_out("sat_up_data", K_DATA, 8'd255);
    tick(1);
    expect_out("sat_up_hold", K_DATA, 8'd255);
    tick(1);
    expect_out("sat_up_hold2", K_DATA, 8'd255);

    // Saturate down at 0.
    clr[0] = 1'b1; dir[0] = DIR_DOWN;
    tick(2);
    expect_out("clr_ovf", K_OVF, 8'h00);
    clr[0] = 1'b0;
    tick(1);
    expect_out("sat_down_ovf", K_OVF, 8'h01);
    tick(1);
    expect_out("sat_down_hold", K_DATA, 8'd0);
    tick(1);
    expect_out("sat_down_hold2", K_DATA, 8'd0);

    // All channels counting in lock-step from 0.
    clr = '1; dir = '1; sat_mode = MODE_WRAP; en_in = '1;
    tick(20);
    expect_out("all_endb", K_ENDB, 8'h0F);
    clr = '0;
    tick(255);
    expect_out("all_255_ovf", K_OVF, 8'h00);
    clr[1] = 1'b1; sel = 2'd1;
    tick(1);
    expect_out("clr_priority_ovf", K_OVF,  8'h0D);
    expect_out("sel1_255",         K_DATA, 8'd255);
    clr[1] = 1'b0; sel = 2'd0;
    tick(1);
    expect_out("ch0_wrapped", K_DATA, 8'd0);
    sel = 2'd2;
    tick(1);
    expect_out("ch2_count1", K_DATA, 8'd1);

    // Scaled output.
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0; m_a = 3'd3; m_b = 3'd5; sel = 2'd2; mul_en = 1'b1;
    tick(10);
    expect_out("mul_150",  K_DATA, 8'd150);
    expect_out("mul_ovf",  K_OVF,  8'h09);
    m_a = 3'd7; m_b = 3'd7;
    tick(245);
    expect_out("mul_207", K_DATA, 8'd207);
    tick(1);
    expect_out("mul_trunc_zero", K_DATA, 8'd0);

    // Reset mid-count.
    mul_en = 1'b0; sel = 2'd0;
    tick(2);
    rst_n = 1'b0;
    expect_out("midrst_data", K_DATA, 8'd0);
    expect_out("midrst_ovf",  K_OVF,  8'd0);
    expect_out("midrst_endb", K_ENDB, 8'd0);
    tick(3);
    expect_out("midrst_hold_ovf", K_OVF, 8'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      expect_out("relat_endb", K_ENDB, (k == 18) ? 8'h0F : 8'h00);
      expect_out("relat_data", K_DATA, 8'd0);
    end
    tick(1);
    expect_out("resume_data0", K_DATA, 8'd0);
    tick(1);
    expect_out("resume_data1", K_DATA, 8'd1);

    tick(2);
    if (q_exp.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
